// File: rtl/connect4_pkg.sv
// rtl/connect4_pkg.sv - shared Connect4 board constants and index helpers
package connect4_pkg;

    localparam int DEFAULT_COLS = 4;
    localparam int DEFAULT_ROWS = 4;
    localparam int MAX_COLS     = 8;
    localparam int COL_IDX_W    = 3;
    localparam int ROW_IDX_W    = 4;
    localparam int CELL_IDX_W   = 7;

    typedef struct packed {
        logic                 valid;
        logic [COL_IDX_W-1:0] index;
    } onehot_idx_t;

    // Unused upper select bits must be padded with ones by the caller.
    function automatic onehot_idx_t onehot_n_index(input logic [MAX_COLS-1:0] sel_n);
        onehot_idx_t result;
        int          zeros;
        result = '0;
        zeros  = 0;
        for (int i = 0; i < MAX_COLS; i++) begin
            if (!sel_n[i]) begin
                zeros++;
                result.index = COL_IDX_W'(i);
            end
        end
        result.valid = (zeros == 1);
        return result;
    endfunction

    function automatic logic [CELL_IDX_W-1:0] cell_index(
        input logic [ROW_IDX_W-1:0] row,
        input logic [COL_IDX_W-1:0] col,
        input int                   cols
    );
        return CELL_IDX_W'(row) * CELL_IDX_W'(cols) + CELL_IDX_W'(col);
    endfunction

endpackage

// File: rtl/move_history_lifo.sv
// rtl/move_history_lifo.sv - move-history stack of column indices for undo
module move_history_lifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] count;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;

    assign wr_idx   = IDX_W'(count);
    assign rd_idx   = IDX_W'(count - PTR_W'(1));
    assign empty    = (count == '0);
    assign full     = (count == PTR_W'(DEPTH));
    // Top of stack is visible combinationally so a pop can use it in the same cycle.
    assign data_out = mem[rd_idx];

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            count <= '0;
        end else if (push && !full) begin
            mem[wr_idx] <= data_in;
            count       <= count + PTR_W'(1);
        end else if (pop && !empty) begin
            count <= count - PTR_W'(1);
        end
    end

endmodule

// File: rtl/column_drop_allocator.sv
// rtl/column_drop_allocator.sv - Connect4 column drop allocator with undo history
module column_drop_allocator
    import connect4_pkg::*;
#(
    parameter  int COLS  = DEFAULT_COLS,
    parameter  int ROWS  = DEFAULT_ROWS,
    localparam int CELLS = COLS * ROWS,
    localparam int POS_W = $clog2(CELLS),
    localparam int CNT_W = $clog2(ROWS + 1),
    localparam int COL_W = $clog2(COLS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    input  logic [COLS-1:0]  col_sel_n,
    input  logic             undo,
    input  logic             clear,
    output logic             done,
    output logic             invalid,
    output logic [POS_W-1:0] cell_pos,
    output logic [CNT_W-1:0] row_out,
    output logic [COL_W-1:0] col_out,
    output logic [COLS-1:0]  col_full,
    output logic             board_full,
    output logic [POS_W:0]   move_count
);

    logic [CNT_W-1:0]    counter [COLS];
    logic [MAX_COLS-1:0] sel_padded;
    onehot_idx_t         hit;
    logic [COL_W-1:0]    req_col;
    logic [CNT_W-1:0]    req_cnt;
    logic                req_ok;
    logic [COL_W-1:0]    undo_col;
    logic [CNT_W-1:0]    undo_cnt;
    logic                hist_empty;
    logic                hist_full;
    logic                do_push;
    logic                do_pop;

    always_comb begin
        sel_padded             = '1;
        sel_padded[COLS-1:0]   = col_sel_n;
        hit                    = onehot_n_index(sel_padded);
        req_col                = COL_W'(hit.index);
        req_cnt                = counter[req_col];
        req_ok                 = hit.valid && (int'(hit.index) < COLS)
                                 && (req_cnt < CNT_W'(ROWS)) && !hist_full;
        undo_cnt               = counter[undo_col] - CNT_W'(1);
        do_push                = !clear && !undo && req && req_ok;
        do_pop                 = !clear && undo && !hist_empty;
    end

    move_history_lifo #(
        .DEPTH (CELLS),
        .WIDTH (COL_W)
    ) u_history (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (do_push),
        .pop      (do_pop),
        .clear    (clear),
        .data_in  (req_col),
        .data_out (undo_col),
        .empty    (hist_empty),
        .full     (hist_full)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < COLS; k++) counter[k] <= '0;
            done       <= 1'b0;
            invalid    <= 1'b0;
            cell_pos   <= '0;
            row_out    <= '0;
            col_out    <= '0;
            col_full   <= '0;
            board_full <= 1'b0;
            move_count <= '0;
        end else begin
            done <= 1'b0;
            if (clear) begin
                for (int k = 0; k < COLS; k++) counter[k] <= '0;
                done       <= 1'b1;
                invalid    <= 1'b0;
                cell_pos   <= '0;
                row_out    <= '0;
                col_out    <= '0;
                col_full   <= '0;
                board_full <= 1'b0;
                move_count <= '0;
            end else if (undo) begin
                done <= 1'b1;
                if (!hist_empty) begin
                    // The freed cell sits at the column's new (decremented) height.
                    counter[undo_col]  <= undo_cnt;
                    col_full[undo_col] <= 1'b0;
                    board_full         <= 1'b0;
                    move_count         <= move_count - (POS_W+1)'(1);
                    cell_pos           <= POS_W'(cell_index(ROW_IDX_W'(undo_cnt),
                                                            COL_IDX_W'(undo_col), COLS));
                    row_out            <= undo_cnt;
                    col_out            <= undo_col;
                    invalid            <= 1'b0;
                end else begin
                    invalid <= 1'b1;
                end
            end else if (req) begin
                done <= 1'b1;
                if (req_ok) begin
                    counter[req_col]  <= req_cnt + CNT_W'(1);
                    col_full[req_col] <= ((req_cnt + CNT_W'(1)) == CNT_W'(ROWS));
                    board_full        <= ((move_count + (POS_W+1)'(1)) == (POS_W+1)'(CELLS));
                    move_count        <= move_count + (POS_W+1)'(1);
                    cell_pos          <= POS_W'(cell_index(ROW_IDX_W'(req_cnt),
                                                           COL_IDX_W'(req_col), COLS));
                    row_out           <= req_cnt;
                    col_out           <= req_col;
                    invalid           <= 1'b0;
                end else begin
                    invalid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_column_drop_allocator.sv
// tb/tb_column_drop_allocator.sv - self-checking bench for column_drop_allocator
module tb_column_drop_allocator;

    localparam int COLS  = 4;
    localparam int ROWS  = 4;
    localparam int CELLS = COLS * ROWS;
    localparam int POS_W = 4;
    localparam int CNT_W = 3;
    localparam int COL_W = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req = 1'b0;
    logic             undo = 1'b0;
    logic             clear = 1'b0;
    logic [COLS-1:0]  col_sel_n = '1;
    logic             done;
    logic             invalid;
    logic [POS_W-1:0] cell_pos;
    logic [CNT_W-1:0] row_out;
    logic [COL_W-1:0] col_out;
    logic [COLS-1:0]  col_full;
    logic             board_full;
    logic [POS_W:0]   move_count;

    int n_cmp  = 0;
    int n_fail = 0;

    int heights [COLS];
    int hist [$];
    int e_done, e_inv, e_cell, e_row, e_col;
    bit rc_known;

    always #5 clk = ~clk;

    column_drop_allocator #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .col_sel_n  (col_sel_n),
        .undo       (undo),
        .clear      (clear),
        .done       (done),
        .invalid    (invalid),
        .cell_pos   (cell_pos),
        .row_out    (row_out),
        .col_out    (col_out),
        .col_full   (col_full),
        .board_full (board_full),
        .move_count (move_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < COLS; k++) heights[k] = 0;
        hist.delete();
        e_done = 0; e_inv = 0; e_cell = 0; e_row = 0; e_col = 0;
        rc_known = 1'b1;
    endtask

    task automatic model(input bit r, input logic [COLS-1:0] sel, input bit u, input bit c);
        int k, zeros;
        e_done = 0;
        if (c) begin
            for (int i = 0; i < COLS; i++) heights[i] = 0;
            hist.delete();
            e_done = 1; e_inv = 0; e_cell = 0;
            rc_known = 1'b0;
        end else if (u) begin
            e_done = 1;
            if (hist.size() == 0) begin
                e_inv = 1;
            end else begin
                k = hist.pop_back();
                heights[k] = heights[k] - 1;
                e_inv = 0;
                e_cell = heights[k] * COLS + k;
                e_row = heights[k]; e_col = k;
                rc_known = 1'b1;
            end
        end else if (r) begin
            e_done = 1;
            zeros = 0; k = 0;
            for (int i = 0; i < COLS; i++) if (sel[i] == 1'b0) begin zeros++; k = i; end
            if (zeros == 1 && heights[k] < ROWS) begin
                e_cell = heights[k] * COLS + k;
                e_row = heights[k]; e_col = k;
                rc_known = 1'b1;
                heights[k] = heights[k] + 1;
                hist.push_back(k);
                e_inv = 0;
            end else begin
                e_inv = 1;
            end
        end
    endtask

    task automatic compare();
        logic [COLS-1:0] e_full;
        for (int k = 0; k < COLS; k++) e_full[k] = (heights[k] == ROWS);
        check("done", 32'(done), 32'(e_done));
        check("invalid", 32'(invalid), 32'(e_inv));
        check("cell_pos", 32'(cell_pos), 32'(e_cell));
        if (rc_known) begin
            check("row_out", 32'(row_out), 32'(e_row));
            check("col_out", 32'(col_out), 32'(e_col));
        end
        check("col_full", 32'(col_full), 32'(e_full));
        check("move_count", 32'(move_count), 32'(hist.size()));
        check("board_full", 32'(board_full), 32'(hist.size() == CELLS));
    endtask

    task automatic step(input bit r, input logic [COLS-1:0] sel, input bit u, input bit c);
        req = r; col_sel_n = sel; undo = u; clear = c;
        model(r, sel, u, c);
        @(posedge clk); #1;
        compare();
        req = 1'b0; undo = 1'b0; clear = 1'b0; col_sel_n = '1;
    endtask

    initial begin
        logic [COLS-1:0] rsel;
        bit rr, ru, rc;

        model_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        compare();
        check("reset_cell", 32'(cell_pos), 32'd0);
        rst_n = 1'b1;

        step(1, 4'b1101, 0, 0);
        check("tp1_cell_a", 32'(cell_pos), 32'd1);
        step(1, 4'b1101, 0, 0);
        check("tp1_cell_b", 32'(cell_pos), 32'd5);
        check("tp1_row_b", 32'(row_out), 32'd1);
        check("tp1_count", 32'(move_count), 32'd2);
        step(0, 4'b1111, 0, 0);
        step(0, 4'b1111, 0, 1);

        for (int i = 0; i < 4; i++) begin
            step(1, 4'b1110, 0, 0);
            check("tp2_cell", 32'(cell_pos), 32'(i * 4));
        end
        check("tp2_full", 32'(col_full), 32'b0001);
        step(1, 4'b1110, 0, 0);
        check("tp2_over_inv", 32'(invalid), 32'd1);
        check("tp2_over_cell", 32'(cell_pos), 32'd12);

        step(1, 4'b1100, 0, 0);
        check("tp3_multi_inv", 32'(invalid), 32'd1);
        step(1, 4'b1111, 0, 0);
        check("tp3_none_inv", 32'(invalid), 32'd1);
        step(0, 4'b1111, 0, 1);

        step(1, 4'b1011, 0, 0);
        step(0, 4'b1111, 1, 0);
        check("tp4_undo_cell", 32'(cell_pos), 32'd2);
        check("tp4_undo_count", 32'(move_count), 32'd0);
        step(0, 4'b1111, 1, 0);
        check("tp4_empty_inv", 32'(invalid), 32'd1);

        step(1, 4'b0111, 0, 0);
        step(1, 4'b1110, 1, 0);
        check("tp5_undo_wins", 32'(cell_pos), 32'd3);
        check("tp5_count", 32'(move_count), 32'd0);
        step(1, 4'b1110, 0, 0);
        step(1, 4'b1110, 1, 1);
        check("tp5_clear_full", 32'(col_full), 32'd0);
        check("tp5_clear_count", 32'(move_count), 32'd0);

        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++)
                step(1, ~(4'(1) << c), 0, 0);
        check("tp6_board_full", 32'(board_full), 32'd1);

        rst_n = 1'b0; req = 1'b1; col_sel_n = 4'b1110;
        model_reset();
        @(posedge clk); #1;
        compare();
        rst_n = 1'b1; req = 1'b0; col_sel_n = '1;
        step(1, 4'b0111, 0, 0);
        check("tp6_after_reset", 32'(cell_pos), 32'd3);

        for (int i = 0; i < 400; i++) begin
            int mode;
            mode = int'($urandom_range(0, 9));
            if (mode < 7)       rsel = ~(4'(1) << $urandom_range(0, 3));
            else if (mode == 7) rsel = 4'b1111;
            else                rsel = 4'($urandom);
            rr = ($urandom_range(0, 5) != 0);
            ru = ($urandom_range(0, 4) == 0);
            rc = ($urandom_range(0, 39) == 0);
            step(rr, rsel, ru, rc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/column_drop_allocator.md
Name: column_drop_allocator

Overview:
- Parametrised successor to the single-column drop calculator.
- Tracks the fill height of every column on a COLS x ROWS Connect4 board.
- Each column-drop request is converted into a linear cell index (row*COLS + col), or rejected.
- Keeps a move-history LIFO so moves can be undone; exposes per-column-full and board-full flags to the game controller and display logic.

Parameters:
COLS, 4, number of board columns (2..8)
ROWS, 4, number of board rows (2..8)
CELLS, COLS*ROWS, derived; total cells
POS_W, $clog2(CELLS), derived; cell index width
CNT_W, $clog2(ROWS+1), derived; per-column counter width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
req  in  1  drop request, sampled every cycle
col_sel_n  in  COLS  active-low one-hot column select (bit k low = column k)
undo  in  1  pop last move, sampled every cycle
clear  in  1  empty the board without reset
done  out  1  one-cycle pulse: result outputs valid
invalid  out  1  valid with done: operation rejected
cell_pos  out  POS_W  cell placed (req) or freed (undo)
row_out  out  CNT_W  row of cell_pos
col_out  out  $clog2(COLS)  column of cell_pos
col_full  out  COLS  bit k high when column k holds ROWS pieces
board_full  out  1  high when all CELLS occupied
move_count  out  POS_W+1  number of pieces on board

Behaviour:
- Reset, checked on clk edge while rst_n=0:
  - all column counters, history and move_count go to 0.
  - done, invalid, cell_pos, row_out, col_out, col_full and board_full go to 0.
- Priority per cycle: clear > undo > req. Lower-priority inputs in the same cycle are ignored; they produce no pulse and are not queued.
- Latency: a command sampled on edge N gives outputs on edge N+1. done is high for exactly one cycle. Back-to-back commands are accepted every cycle.
- req path:
  - Valid when col_sel_n has exactly one zero bit k and counter[k] < ROWS.
  - If valid: cell_pos = counter[k]*COLS + k, row_out = counter[k], col_out = k. counter[k] increments, k is pushed onto the history, move_count increments, and invalid = 0.
  - Otherwise (all ones, multiple zeros, or column full): done = 1 and invalid = 1. All state is unchanged. cell_pos, row_out and col_out hold their previous values.
- undo path:
  - If history is non-empty: pop column k, decrement counter[k], and decrement move_count. Report the freed cell as cell_pos = (new counter[k])*COLS + k, with matching row_out and col_out. invalid = 0.
  - If history is empty: done = 1 and invalid = 1; no state change.
- clear: counters, history and move_count go to 0. done = 1, invalid = 0, cell_pos = 0.
- Flags:
  - col_full[k] = (counter[k] == ROWS).
  - board_full = (move_count == CELLS).
  - Both are registered and updated in the same cycle as the counters.
- Width rules:
  - Multiplication is done at POS_W width; no overflow is possible because counter < ROWS on a valid req.
  - Counters never exceed ROWS or go below 0.
  - History depth is exactly CELLS, so a push is never attempted when full.
- rst_n low in the cycle of a command: reset wins and no done pulse is produced.
- Idle cycles (no command): done = 0; all other outputs hold.

Decomposition:
- Shared package connect4_pkg holds:
  - default COLS and ROWS constants;
  - function onehot_n_index (returns index and a valid bit for an active-low one-hot vector);
  - function cell_index(row, col).
- One sub-module: move_history_lifo.
  - Parameters: DEPTH = CELLS, width $clog2(COLS).
  - Signals: push, pop, clear, data in/out, empty, full.
  - Synchronous; push and pop are mutually exclusive by construction.

Test Plan:
- COLS=ROWS=4, after reset: req with col_sel_n=4'b1101 twice -> done pulses, cell_pos 1 then 5, row_out 0 then 1, col_out 1, move_count 2.
- Four reqs on 4'b1110 -> cell_pos 0,4,8,12 and col_full=4'b0001. Fifth req on the same column -> done=1, invalid=1, counters unchanged, cell_pos still 12.
- req col_sel_n=4'b1100, then 4'b1111 -> both invalid=1, move_count unchanged.
- req on 4'b1011 (cell 2), then undo -> cell_pos 2, invalid=0, move_count 0. Second undo -> invalid=1.
- Same cycle req=1, undo=1, clear=0 after one move in column 3 -> undo wins, cell_pos 3, no placement. With clear=1 also asserted -> board empty and all col_full=0.
- Fill all 16 cells -> board_full=1 on the 16th done. Then rst_n=0 for one cycle mid-req -> no done pulse, all outputs 0, next req on 4'b0111 gives cell_pos 3.
